// File: rtl/sample_frame_streamer_if.sv
// Load-side and stream-side handshake bundle for sample_frame_streamer.
// The master drives writes, start and ce; the slave is the streamer.
interface sample_frame_streamer_if #(
    parameter int DATA_W = 16
);
    logic                  wr_en;
    logic [2*DATA_W-1:0]   wr_data;
    logic                  wr_ready;
    logic                  full;
    logic                  start;
    logic                  ce;
    logic [2*DATA_W-1:0]   out_data;
    logic                  out_valid;
    logic                  out_last;
    logic                  busy;

    modport master (
        output wr_en, wr_data, start, ce,
        input  wr_ready, full, out_data, out_valid, out_last, busy
    );

    modport slave (
        input  wr_en, wr_data, start, ce,
        output wr_ready, full, out_data, out_valid, out_last, busy
    );
endinterface

// File: rtl/sample_frame_streamer.sv
// Buffers one frame of packed complex samples and replays it one sample per ce strobe.
// Define STREAMER_BIT_REVERSE_EN to stream the frame in bit-reversed index order.
module sample_frame_streamer #(
    parameter int DATA_W = 16,
    parameter int N_LOG2 = 3
) (
    input  logic                    clk,
    input  logic                    rst,
    sample_frame_streamer_if.slave  bus
);
    localparam int N = 1 << N_LOG2;
    localparam logic [N_LOG2-1:0] LAST_IDX = '1;
    localparam logic [N_LOG2-1:0] ONE_IDX  = N_LOG2'(1);

    typedef enum logic [1:0] {
        ST_LOAD,
        ST_FULL,
        ST_STREAM
    } state_t;

    state_t              state;
    logic [N_LOG2-1:0]   wr_ptr;
    logic [N_LOG2-1:0]   rd_ptr;
    logic [N_LOG2-1:0]   rd_next;
    logic [2*DATA_W-1:0] mem [N];

    function automatic logic [N_LOG2-1:0] addr_of(input logic [N_LOG2-1:0] idx);
        logic [N_LOG2-1:0] r;
        r = '0;
`ifdef STREAMER_BIT_REVERSE_EN
        for (int b = 0; b < N_LOG2; b++) begin
            r[b] = idx[N_LOG2-1-b];
        end
`else
        r = idx;
`endif
        return r;
    endfunction

    assign rd_next = rd_ptr + ONE_IDX;

    // NOTE: the sample array carries no reset; it is only visible behind out_valid,
    // and leaving it out of the reset tree lets it map onto plain storage.
    always_ff @(posedge clk) begin
        if (state == ST_LOAD && bus.wr_en) begin
            mem[wr_ptr] <= bus.wr_data;
        end
    end

    // NOTE: every register here uses non-blocking assignment so all state moves
    // together at the edge regardless of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= ST_LOAD;
            wr_ptr        <= '0;
            rd_ptr        <= '0;
            bus.out_data  <= '0;
            bus.out_valid <= 1'b0;
            bus.out_last  <= 1'b0;
            bus.busy      <= 1'b0;
            bus.full      <= 1'b0;
            bus.wr_ready  <= 1'b1;
        end else begin
            unique case (state)
                ST_LOAD: begin
                    if (bus.wr_en) begin
                        wr_ptr <= wr_ptr + ONE_IDX;
                        if (wr_ptr == LAST_IDX) begin
                            state        <= ST_FULL;
                            bus.wr_ready <= 1'b0;
                            bus.full     <= 1'b1;
                        end
                    end
                end
                ST_FULL: begin
                    if (bus.start) begin
                        state         <= ST_STREAM;
                        rd_ptr        <= '0;
                        bus.out_data  <= mem[addr_of('0)];
                        bus.out_valid <= 1'b1;
                        bus.out_last  <= (N_LOG2 == 0);
                        bus.busy      <= 1'b1;
                        bus.full      <= 1'b0;
                    end
                end
                ST_STREAM: begin
                    if (bus.ce) begin
                        if (rd_ptr == LAST_IDX) begin
                            // Final sample consumed: out_data keeps its last value.
                            state         <= ST_LOAD;
                            rd_ptr        <= '0;
                            bus.out_valid <= 1'b0;
                            bus.out_last  <= 1'b0;
                            bus.busy      <= 1'b0;
                            bus.wr_ready  <= 1'b1;
                        end else begin
                            rd_ptr       <= rd_next;
                            bus.out_data <= mem[addr_of(rd_next)];
                            bus.out_last <= (rd_next == LAST_IDX);
                        end
                    end
                end
                default: begin
                    state <= ST_LOAD;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_sample_frame_streamer.sv
// Scoreboard bench for sample_frame_streamer: expected samples are queued at start
// and compared while the stream is live; honours STREAMER_BIT_REVERSE_EN.
module tb_sample_frame_streamer;
    localparam int DATA_W = 16;
    localparam int N_LOG2 = 3;
    localparam int N      = 8;

    typedef struct {
        logic [31:0] data;
        logic        last;
    } exp_t;

    logic clk;
    logic rst;
    sample_frame_streamer_if #(.DATA_W(DATA_W)) bus ();

    sample_frame_streamer #(.DATA_W(DATA_W), .N_LOG2(N_LOG2)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int          checks = 0;
    int          errors = 0;
    exp_t        sb[$];
    logic [31:0] frame [N];
    logic [31:0] last_exp;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic int stream_idx(input int i);
        int r;
        r = i;
`ifdef STREAMER_BIT_REVERSE_EN
        r = 0;
        for (int b = 0; b < N_LOG2; b++) begin
            if (((i >> b) & 1) != 0) r = r | (1 << (N_LOG2 - 1 - b));
        end
`endif
        return r;
    endfunction

    // Live output is compared every cycle against the head; it is popped only on ce.
    always @(negedge clk) begin
        if (!rst && bus.out_valid) begin
            if (sb.size() == 0) begin
                check("unexpected_valid", 64'(bus.out_valid), 64'd0);
            end else begin
                check("out_data", 64'(bus.out_data), 64'(sb[0].data));
                check("out_last", 64'(bus.out_last), 64'(sb[0].last));
                if (bus.ce) void'(sb.pop_front());
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Loads frame[] back to back; optionally raises start alongside the final write.
    task automatic load_frame(input bit start_on_last);
        for (int k = 0; k < N; k++) begin
            bus.wr_en   = 1'b1;
            bus.wr_data = frame[k];
            bus.start   = start_on_last && (k == N - 1);
            if (k == N - 1) check("full_before_last", 64'(bus.full), 64'd0);
            tick();
        end
        bus.wr_en = 1'b0;
        bus.start = 1'b0;
        check("full_after_load", 64'(bus.full), 64'd1);
        check("wr_ready_full", 64'(bus.wr_ready), 64'd0);
        check("busy_full", 64'(bus.busy), 64'd0);
    endtask

    task automatic start_stream();
        for (int i = 0; i < N; i++) begin
            exp_t e;
            e.data = frame[stream_idx(i)];
            e.last = (i == N - 1);
            sb.push_back(e);
            last_exp = e.data;
        end
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        check("valid_latency", 64'(bus.out_valid), 64'd1);
        check("busy_stream", 64'(bus.busy), 64'd1);
    endtask

    // Drives ce from a repeating 3-bit pattern until the scoreboard drains.
    task automatic run_stream(input logic [2:0] pat);
        int cyc;
        cyc = 0;
        while (sb.size() > 0 && cyc < 200) begin
            bus.ce = pat[cyc % 3];
            tick();
            cyc++;
        end
        bus.ce = 1'b0;
        check("stream_drained", 64'(sb.size()), 64'd0);
        check("valid_after", 64'(bus.out_valid), 64'd0);
        check("last_after", 64'(bus.out_last), 64'd0);
        check("busy_after", 64'(bus.busy), 64'd0);
        check("wr_ready_after", 64'(bus.wr_ready), 64'd1);
        check("data_held", 64'(bus.out_data), 64'(last_exp));
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_wr_ready"}, 64'(bus.wr_ready), 64'd1);
        check({tag, "_full"}, 64'(bus.full), 64'd0);
        check({tag, "_valid"}, 64'(bus.out_valid), 64'd0);
        check({tag, "_last"}, 64'(bus.out_last), 64'd0);
        check({tag, "_busy"}, 64'(bus.busy), 64'd0);
        check({tag, "_data"}, 64'(bus.out_data), 64'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst         = 1'b1;
        bus.wr_en   = 1'b0;
        bus.wr_data = '0;
        bus.start   = 1'b0;
        bus.ce      = 1'b0;
        last_exp    = '0;
        tick();
        tick();
        rst = 1'b0;
        tick();
        tick();
        check_reset_outputs("reset");

        // Natural ramp, start on the final write is ignored, then a clean stream.
        for (int k = 0; k < N; k++) frame[k] = 32'h0001_0000 * k + k;
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        check("start_in_load", 64'(bus.busy), 64'd0);
        load_frame(1'b1);
        tick();
        check("still_full", 64'(bus.full), 64'd1);
        check("no_stream_yet", 64'(bus.out_valid), 64'd0);
        // Writes while FULL must not disturb the frame.
        bus.wr_en   = 1'b1;
        bus.wr_data = 32'hDEAD_BEEF;
        tick();
        tick();
        check("full_ignores_wr", 64'(bus.full), 64'd1);
        // Writes continue through the stream, including on the final ce.
        bus.ce = 1'b1;
        start_stream();
        run_stream(3'b111);
        bus.wr_en = 1'b0;

        // Signed extremes with ce toggling 1,0,0.
        for (int k = 0; k < N; k++) frame[k] = {16'(16'h8000 + k), 16'(16'hFFFF - k)};
        frame[3] = 32'hFFFF_8000;
        frame[6] = 32'h7FFF_0001;
        load_frame(1'b0);
        start_stream();
        run_stream(3'b001);

        // Reset after three samples streamed, then after a partial load.
        for (int k = 0; k < N; k++) frame[k] = 32'hA5A5_0000 | k;
        load_frame(1'b0);
        start_stream();
        bus.ce = 1'b1;
        for (int i = 0; i < 3; i++) tick();
        rst = 1'b1;
        #1;
        check_reset_outputs("rst_stream");
        sb.delete();
        bus.ce = 1'b0;
        tick();
        rst = 1'b0;
        tick();
        bus.wr_en = 1'b1;
        for (int k = 0; k < 3; k++) begin
            bus.wr_data = 32'h5555_0000 | k;
            tick();
        end
        bus.wr_en = 1'b0;
        rst = 1'b1;
        #1;
        check_reset_outputs("rst_load");
        tick();
        rst = 1'b0;
        tick();
        for (int k = 0; k < N; k++) frame[k] = 32'h1234_0000 + 32'h0003_0007 * k;
        load_frame(1'b0);
        start_stream();
        run_stream(3'b011);

        check("scoreboard_empty", 64'(sb.size()), 64'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
